io_signature_harness: RTL and testbench



---
 rtl/io_signature_harness_if.sv | 29 ++
 rtl/io_signature_harness.sv | 155 +++++++++++++++
 tb/tb_io_signature_harness.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/io_signature_harness_if.sv
// Bus bundle for io_signature_harness: capture control, monitored data and signature results.
interface io_signature_harness_if #(
    parameter int unsigned OUT_W    = 8,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned SIG_W    = 16,
    parameter int unsigned CNT_W    = 16
);
    logic                        start;
    logic                        abort;
    logic [CNT_W-1:0]            win_len;
    logic [CHANNELS*OUT_W-1:0]   data_in;
    logic [OUT_W-1:0]            trig_value;
    logic [OUT_W-1:0]            trig_mask;
    logic                        busy;
    logic                        done;
    logic                        sig_valid;
    logic [SIG_W-1:0]            signature;
    logic [CNT_W-1:0]            sample_count;

    modport master (
        output start, abort, win_len, data_in, trig_value, trig_mask,
        input  busy, done, sig_valid, signature, sample_count
    );

    modport slave (
        input  start, abort, win_len, data_in, trig_value, trig_mask,
        output busy, done, sig_valid, signature, sample_count
    );
endinterface

// File: rtl/io_signature_harness.sv
// MISR signature capture of equal-width output channels over a programmable window.
// Define SIG_TRIGGER_EN to build the ARM state that waits for a masked ch0 trigger.
module io_signature_harness #(
    parameter int unsigned     OUT_W    = 8,
    parameter int unsigned     CHANNELS = 3,
    parameter int unsigned     SIG_W    = 16,
    parameter int unsigned     CNT_W    = 16,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(16'h1021),
    parameter logic [SIG_W-1:0] SEED    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    io_signature_harness_if.slave bus
);
    localparam int unsigned DATA_W  = CHANNELS * OUT_W;
    localparam int unsigned FOLD_W  = ((DATA_W + SIG_W - 1) / SIG_W) * SIG_W;
    localparam int unsigned N_SLICE = FOLD_W / SIG_W;

`ifdef SIG_TRIGGER_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;
`endif

    state_t           state;
    logic             busy_q;
    logic             done_q;
    logic             valid_q;
    logic [SIG_W-1:0] sig_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] win_q;

    logic [FOLD_W-1:0] padded;
    logic [SIG_W-1:0]  fold;
    logic [SIG_W-1:0]  sig_next;
    logic [CNT_W-1:0]  cnt_inc;
    logic              last;
    logic              trig_hit;

    // Zero-pad the channel bus to whole signature slices and XOR them together.
    always_comb begin
        padded = FOLD_W'(bus.data_in);
        fold   = '0;
        for (int i = 0; i < int'(N_SLICE); i++) begin
            fold = fold ^ padded[i*SIG_W +: SIG_W];
        end
    end

    assign sig_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign last     = (cnt_inc == win_q);

`ifdef SIG_TRIGGER_EN
    assign trig_hit = ((bus.data_in[OUT_W-1:0] ^ bus.trig_value) & bus.trig_mask) == '0;
`else
    logic unused_trig;
    assign trig_hit    = 1'b0;
    assign unused_trig = ^{bus.trig_value, bus.trig_mask, trig_hit};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            sig_q   <= SEED;
            cnt_q   <= '0;
            win_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        sig_q   <= SEED;
                        cnt_q   <= '0;
                        win_q   <= bus.win_len;
                        valid_q <= 1'b0;
                        if (bus.win_len == '0) begin
                            state   <= S_DONE;
                            done_q  <= 1'b1;
                            valid_q <= 1'b1;
                        end else begin
                            busy_q <= 1'b1;
`ifdef SIG_TRIGGER_EN
                            state  <= S_ARM;
`else
                            state  <= S_CAPTURE;
`endif
                        end
                    end
                end
`ifdef SIG_TRIGGER_EN
                // The matching cycle is itself the first sample.
                S_ARM: begin
                    if (bus.abort) begin
                        state   <= S_IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end else if (trig_hit) begin
                        sig_q <= sig_next;
                        cnt_q <= cnt_inc;
                        if (last) begin
                            state   <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            valid_q <= 1'b1;
                        end else begin
                            state <= S_CAPTURE;
                        end
                    end
                end
`endif
                S_CAPTURE: begin
                    if (bus.abort) begin
                        state   <= S_IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end else begin
                        sig_q <= sig_next;
                        cnt_q <= cnt_inc;
                        if (last) begin
                            state   <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            valid_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.sig_valid    = valid_q;
    assign bus.signature    = sig_q;
    assign bus.sample_count = cnt_q;
endmodule

// File: tb/tb_io_signature_harness.sv
// Directed self-checking bench for io_signature_harness with hand-computed signatures.
module tb_io_signature_harness;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    io_signature_harness_if #(.OUT_W(8), .CHANNELS(3), .SIG_W(16), .CNT_W(16)) bus ();

    io_signature_harness dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Idle one cycle, pulse start, then wait (bounded) for done.
    task automatic run(input logic [15:0] wl, input logic [23:0] d, output int cyc);
        tick;
        bus.win_len = wl;
        bus.data_in = d;
        bus.start   = 1'b1;
        tick;
        bus.start = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 200) begin
            tick;
            cyc++;
        end
    endtask

`ifdef SIG_TRIGGER_EN
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [23:0] d);
        logic [15:0] f;
        f = d[15:0] ^ {8'h00, d[23:16]};
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ f;
    endfunction
`endif

    initial begin
        int   cyc;
        logic bad;
        n_checks       = 0;
        n_pass         = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.win_len    = '0;
        bus.data_in    = '0;
        bus.trig_value = 8'hA5;
        bus.trig_mask  = 8'h00;
        repeat (3) tick;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_valid", 32'(bus.sig_valid), 32'd0);
        check("rst_sig", 32'(bus.signature), 32'h0);
        check("rst_cnt", 32'(bus.sample_count), 32'd0);
        reset = 1'b0;

        run(16'd5, 24'h000000, cyc);
        check("zero_done", 32'(bus.done), 32'd1);
        check("zero_latency", 32'(cyc), 32'd6);
        check("zero_sig", 32'(bus.signature), 32'h0000);
        check("zero_cnt", 32'(bus.sample_count), 32'd5);
        check("zero_valid", 32'(bus.sig_valid), 32'd1);
        check("zero_busy", 32'(bus.busy), 32'd0);
        tick;
        check("zero_done_pulse", 32'(bus.done), 32'd0);
        check("zero_valid_sticky", 32'(bus.sig_valid), 32'd1);

        run(16'd1, 24'h001234, cyc);
        check("single_latency", 32'(cyc), 32'd2);
        check("single_sig", 32'(bus.signature), 32'h1234);
        check("single_valid", 32'(bus.sig_valid), 32'd1);

        run(16'd1, 24'hFF1234, cyc);
        check("fold_sig", 32'(bus.signature), 32'h12CB);

        run(16'd2, 24'h001234, cyc);
        check("two_sig", 32'(bus.signature), 32'h365C);
        check("two_cnt", 32'(bus.sample_count), 32'd2);

        run(16'd3, 24'h008000, cyc);
        check("poly_latency", 32'(cyc), 32'd4);
        check("poly_sig", 32'(bus.signature), 32'hB063);

        // A start while in DONE must be ignored.
        run(16'd1, 24'h001234, cyc);
        bus.start   = 1'b1;
        bus.win_len = 16'd5;
        bus.data_in = 24'h000000;
        tick;
        bus.start = 1'b0;
        check("done_start_busy", 32'(bus.busy), 32'd0);
        check("done_start_sig", 32'(bus.signature), 32'h1234);
        check("done_start_done", 32'(bus.done), 32'd0);
        tick;
        check("done_start_idle", 32'(bus.busy), 32'd0);

        run(16'd0, 24'hABCDEF, cyc);
        check("wl0_latency", 32'(cyc), 32'd1);
        check("wl0_sig", 32'(bus.signature), 32'h0000);
        check("wl0_cnt", 32'(bus.sample_count), 32'd0);
        check("wl0_valid", 32'(bus.sig_valid), 32'd1);
        check("wl0_busy", 32'(bus.busy), 32'd0);

        // Abort after four samples, with a coincident start.
        tick;
        bus.win_len = 16'd10;
        bus.data_in = 24'h001234;
        bus.start   = 1'b1;
        tick;
        bus.start = 1'b0;
        check("abort_busy_on", 32'(bus.busy), 32'd1);
        check("abort_valid_clr", 32'(bus.sig_valid), 32'd0);
        repeat (4) tick;
        check("abort_cnt_pre", 32'(bus.sample_count), 32'd4);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_valid", 32'(bus.sig_valid), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_cnt", 32'(bus.sample_count), 32'd4);
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
        end
        check("abort_quiet", 32'(bad), 32'd0);

        // Reset in the middle of a capture.
        bus.win_len = 16'd10;
        bus.data_in = 24'hFF1234;
        bus.start   = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (3) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_valid", 32'(bus.sig_valid), 32'd0);
        check("midrst_sig", 32'(bus.signature), 32'h0);
        check("midrst_cnt", 32'(bus.sample_count), 32'd0);

`ifdef SIG_TRIGGER_EN
        begin
            logic [23:0] seq [8];
            logic [15:0] model;
            int          taken;
            logic        seen_done;
            seq[0] = 24'h000011; seq[1] = 24'h0000A4; seq[2] = 24'h00FF5A;
            seq[3] = 24'h1234A5; seq[4] = 24'h00BEEF; seq[5] = 24'h765432;
            seq[6] = 24'h0000A5; seq[7] = 24'h000000;
            model = 16'h0000;
            taken = 0;
            seen_done = 1'b0;
            bad = 1'b0;
            tick;
            bus.trig_mask = 8'hFF;
            bus.win_len   = 16'd3;
            bus.data_in   = 24'h000000;
            bus.start     = 1'b1;
            tick;
            bus.start = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (!seen_done) begin
                    bus.data_in = seq[i];
                    if (taken < 3 && (taken > 0 || seq[i][7:0] == 8'hA5)) begin
                        model = misr_step(model, seq[i]);
                        taken++;
                    end
                    tick;
                    if (taken < 3 && bus.busy !== 1'b1) bad = 1'b1;
                    if (bus.done === 1'b1) seen_done = 1'b1;
                end
            end
            check("trig_busy", 32'(bad), 32'd0);
            check("trig_done", 32'(seen_done), 32'd1);
            check("trig_cnt", 32'(bus.sample_count), 32'd3);
            check("trig_sig", 32'(bus.signature), 32'(model));
            bus.trig_mask = 8'h00;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
